// File: rtl/ikaopll_bus_writer.sv
// Purpose : serialises 8-bit register writes onto the OPLL CS_n/WR_n/A0/D bus as an
//           address cycle followed by a data cycle, each timed in phiM ticks.
// Latency : 4+2*STROBE_LEN+ADDR_WAIT+DATA_WAIT ticks per write (2+STROBE_LEN+DATA_WAIT
//           on an address-cache hit); READY low for the whole write, so no queueing.
// Option  : IKAOPLL_BUSWR_ADDR_CACHE_EN skips the address cycle when the address repeats.
module ikaopll_bus_writer #(
  parameter int STROBE_LEN = 2,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic       i_EMUCLK,
  input  logic       i_IC_n,
  input  logic       i_phiM_PCEN_n,
  input  logic       i_REQ_VALID,
  input  logic [7:0] i_REQ_ADDR,
  input  logic [7:0] i_REQ_DATA,
  output logic       o_REQ_READY,
  output logic       o_CS_n,
  output logic       o_WR_n,
  output logic       o_A0,
  output logic [7:0] o_D,
  output logic       o_D_OE,
  output logic       o_BUSY
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STB, A_HOLD, A_WAIT, D_SETUP, D_STB, D_HOLD, D_WAIT
  } state_t;

  localparam logic [7:0] STB_LD = 8'(STROBE_LEN);
  localparam logic [7:0] AW_LD  = 8'(ADDR_WAIT);
  localparam logic [7:0] DW_LD  = 8'(DATA_WAIT);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] addr_q, data_q;
  logic       a0_q, a0_nxt;
  logic       rdy_en;
  logic       accept;
  logic       tick;
  logic       cache_hit;

  assign tick = ~i_phiM_PCEN_n;

`ifdef IKAOPLL_BUSWR_ADDR_CACHE_EN
  logic [7:0] cache_addr;
  logic       cache_vld;
  logic       cache_upd;

  assign cache_hit = cache_vld && (cache_addr == i_REQ_ADDR);
  // The address is only cached once its cycle (including recovery) has fully completed.
  assign cache_upd = (state == A_WAIT) && tick && (cnt == 8'd1);

  // Last completed address and its valid bit; reset invalidates it.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      cache_addr <= 8'h00;
      cache_vld  <= 1'b0;
    end else if (cache_upd) begin
      cache_addr <= addr_q;
      cache_vld  <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Next-state and phase counter: STB/WAIT phases load the counter on entry and leave at 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a0_nxt    = a0_q;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // Acceptance is not tick-qualified: any EMUCLK edge with VALID and READY.
        if (rdy_en && i_REQ_VALID) begin
          accept = 1'b1;
          if (cache_hit) begin
            state_nxt = D_SETUP;
            a0_nxt    = 1'b1;
          end else begin
            state_nxt = A_SETUP;
            a0_nxt    = 1'b0;
          end
        end
      end
      A_SETUP: if (tick) begin
        state_nxt = A_STB;
        cnt_nxt   = STB_LD;
      end
      A_STB: if (tick) begin
        if (cnt == 8'd1) state_nxt = A_HOLD;
        else             cnt_nxt   = cnt - 8'd1;
      end
      A_HOLD: if (tick) begin
        state_nxt = A_WAIT;
        cnt_nxt   = AW_LD;
      end
      A_WAIT: if (tick) begin
        if (cnt == 8'd1) begin
          state_nxt = D_SETUP;
          a0_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      D_SETUP: if (tick) begin
        state_nxt = D_STB;
        cnt_nxt   = STB_LD;
      end
      D_STB: if (tick) begin
        if (cnt == 8'd1) state_nxt = D_HOLD;
        else             cnt_nxt   = cnt - 8'd1;
      end
      D_HOLD: if (tick) begin
        state_nxt = D_WAIT;
        cnt_nxt   = DW_LD;
      end
      D_WAIT: if (tick) begin
        if (cnt == 8'd1) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, A0 and request latches; rdy_en keeps READY low until the first edge after reset.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state  <= IDLE;
      cnt    <= 8'h00;
      a0_q   <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 8'h00;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      a0_q   <= a0_nxt;
      rdy_en <= 1'b1;
      if (accept) begin
        addr_q <= i_REQ_ADDR;
        data_q <= i_REQ_DATA;
      end
    end
  end

  // Bus pins decode straight from the state so reset releases CS_n/WR_n without waiting for a clock.
  always_comb begin
    o_CS_n      = 1'b1;
    o_WR_n      = 1'b1;
    o_D_OE      = 1'b0;
    o_D         = 8'h00;
    o_A0        = a0_q;
    o_BUSY      = (state != IDLE);
    o_REQ_READY = rdy_en && (state == IDLE);
    case (state)
      A_SETUP: begin o_CS_n = 1'b0;                 o_D_OE = 1'b1; o_D = addr_q; end
      A_STB:   begin o_CS_n = 1'b0; o_WR_n = 1'b0;  o_D_OE = 1'b1; o_D = addr_q; end
      A_HOLD:  begin                                o_D_OE = 1'b1; o_D = addr_q; end
      D_SETUP: begin o_CS_n = 1'b0;                 o_D_OE = 1'b1; o_D = data_q; end
      D_STB:   begin o_CS_n = 1'b0; o_WR_n = 1'b0;  o_D_OE = 1'b1; o_D = data_q; end
      D_HOLD:  begin                                o_D_OE = 1'b1; o_D = data_q; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Purpose : random-stimulus bench for ikaopll_bus_writer with a tick-level bus model.
// Latency : checks per-write tick totals, strobe widths and pulse gaps.
// Backpressure : requests wait on READY; junk requests are driven while busy.
module tb_ikaopll_bus_writer;

`ifdef IKAOPLL_BUSWR_ADDR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       ic_n = 1'b0;
  logic       pcen_n = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  int         sel = 0;
  int         tmode = 0;
  int         ph = 0;
  int         tick_cnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  logic [1:0] rdy, cs, wr, a0, oe, busy, v;
  logic [7:0] dd [2];
  bit         cvld [2];
  logic [7:0] caddr [2];

  logic       m_rdy, m_cs, m_wr, m_a0, m_oe, m_busy;
  logic [7:0] m_d;

  assign v[0]   = valid && (sel == 0);
  assign v[1]   = valid && (sel == 1);
  assign m_rdy  = rdy[sel];
  assign m_cs   = cs[sel];
  assign m_wr   = wr[sel];
  assign m_a0   = a0[sel];
  assign m_oe   = oe[sel];
  assign m_busy = busy[sel];
  assign m_d    = dd[sel];

  always #5 clk = ~clk;

  ikaopll_bus_writer u_dut0 (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(pcen_n), .i_REQ_VALID(v[0]),
    .i_REQ_ADDR(addr), .i_REQ_DATA(data), .o_REQ_READY(rdy[0]), .o_CS_n(cs[0]),
    .o_WR_n(wr[0]), .o_A0(a0[0]), .o_D(dd[0]), .o_D_OE(oe[0]), .o_BUSY(busy[0])
  );

  ikaopll_bus_writer #(.STROBE_LEN(1), .ADDR_WAIT(1), .DATA_WAIT(1)) u_dut1 (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(pcen_n), .i_REQ_VALID(v[1]),
    .i_REQ_ADDR(addr), .i_REQ_DATA(data), .o_REQ_READY(rdy[1]), .o_CS_n(cs[1]),
    .o_WR_n(wr[1]), .o_A0(a0[1]), .o_D(dd[1]), .o_D_OE(oe[1]), .o_BUSY(busy[1])
  );

  // phiM enable: every 4th edge, or random density about 1 in 3.
  always @(negedge clk) begin
    if (tmode == 0) begin
      ph = (ph + 1) % 4;
      pcen_n = (ph != 0);
    end else begin
      pcen_n = ($urandom_range(0, 2) != 0);
    end
  end

  always @(posedge clk) if (!pcen_n) tick_cnt <= tick_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int p_stb();  return (sel == 1) ? 1 : 2;  endfunction
  function automatic int p_aw();   return (sel == 1) ? 1 : 12; endfunction
  function automatic int p_dw();   return (sel == 1) ? 1 : 84; endfunction

  task automatic do_reset();
    @(negedge clk);
    ic_n = 1'b0;
    repeat (3) @(negedge clk);
    ic_n = 1'b1;
    @(negedge clk);
    cvld[0] = 1'b0;
    cvld[1] = 1'b0;
  endtask

  // One write: model decides whether an address cycle is due and how long the write lasts,
  // then the bus is observed tick by tick until READY returns.
  task automatic run_write(input logic [7:0] a, input logic [7:0] d, input bit pre_acc,
                           input bit hold_next, input logic [7:0] na, input logic [7:0] nd);
    bit         aph, done, prev_low, prev_cs;
    logic       prev_a0;
    int         tot, ta, tr, np, bad_bus, bad_a0, bad_d, k;
    int         fall_t [4];
    int         rise_t [4];
    logic       pa0 [4];
    logic [7:0] pd [4];
    logic       ea0 [2];
    logic [7:0] ed [2];
    aph = !(CACHE_EN && cvld[sel] && (caddr[sel] == a));
    tot = aph ? (4 + 2 * p_stb() + p_aw() + p_dw()) : (2 + p_stb() + p_dw());
    for (int i = 0; i < 4; i++) begin fall_t[i] = 0; rise_t[i] = 0; pa0[i] = 0; pd[i] = 0; end
    if (!pre_acc) begin
      k = 0;
      while (!m_rdy && k < 5000) begin @(negedge clk); k++; end
      check("ready_before_req", m_rdy, 1);
      addr = a; data = d; valid = 1'b1;
      @(negedge clk);
    end
    ta = tick_cnt;
    check("accepted", m_busy, 1);
    if (hold_next) begin addr = na; data = nd; end
    else valid = 1'b0;
    done = 0; prev_low = 0; prev_cs = 1; prev_a0 = m_a0;
    np = 0; bad_bus = 0; bad_a0 = 0; bad_d = 0; tr = 0;
    for (int c = 0; c < 6000 && !done; c++) begin
      if (m_rdy) begin
        done = 1;
        tr = tick_cnt;
      end else begin
        if (!m_wr) begin
          if (m_cs || !m_oe) bad_bus++;
          if (!prev_low && np < 4) begin fall_t[np] = tick_cnt; pa0[np] = m_a0; pd[np] = m_d; end
          if (np < 4 && (m_a0 !== pa0[np] || m_d !== pd[np])) bad_d++;
        end else if (prev_low) begin
          if (np < 4) rise_t[np] = tick_cnt;
          np++;
        end
        prev_low = !m_wr;
        if (!prev_cs && !m_cs && (m_a0 !== prev_a0)) bad_a0++;
        prev_cs = m_cs;
        prev_a0 = m_a0;
        if (!hold_next) begin
          if (tick_cnt < ta + tot - 1) begin
            valid = 1'($urandom_range(0, 1)); addr = 8'($urandom); data = 8'($urandom);
          end else begin
            valid = 1'b0;
          end
        end
        @(negedge clk);
      end
    end
    check("write_done", done, 1);
    check("total_ticks", tr - ta, tot);
    check("strobe_count", np, aph ? 2 : 1);
    ea0[0] = aph ? 1'b0 : 1'b1; ed[0] = aph ? a : d;
    ea0[1] = 1'b1;              ed[1] = d;
    for (int i = 0; i < (aph ? 2 : 1); i++) begin
      check("strobe_width", rise_t[i] - fall_t[i], p_stb());
      check("strobe_a0", pa0[i], ea0[i]);
      check("strobe_d", pd[i], ed[i]);
    end
    // End of address strobe to start of data strobe: hold + recovery + setup.
    if (aph) check("pulse_gap", fall_t[1] - rise_t[0], 2 + p_aw());
    check("bus_during_strobe", bad_bus, 0);
    check("a0_stable_cs_low", bad_a0, 0);
    check("d_stable_in_strobe", bad_d, 0);
    if (aph) begin cvld[sel] = 1'b1; caddr[sel] = a; end
    if (hold_next) begin
      check("b2b_not_early", m_busy, 0);
      @(negedge clk);
      check("b2b_accepted", m_busy, 1);
      check("b2b_ready_low", m_rdy, 0);
    end
  endtask

  initial begin
    int lows;
    logic [7:0] ra;
    cvld[0] = 1'b0; cvld[1] = 1'b0; caddr[0] = 8'h00; caddr[1] = 8'h00;

    // Reset held for 30 clocks: both instances quiet.
    repeat (30) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_cs_n", cs[i], 1);
      check("rst_wr_n", wr[i], 1);
      check("rst_d_oe", oe[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_ready", rdy[i], 0);
      check("rst_a0", a0[i], 0);
      check("rst_d", dd[i], 8'h00);
    end
    ic_n = 1'b1;
    #1;
    check("ready_before_edge", rdy[0], 0);
    @(negedge clk);
    check("ready_after_edge", rdy[0], 1);
    check("ready_after_edge1", rdy[1], 1);

    // Single write, periodic ticks.
    run_write(8'h10, 8'hAC, 0, 0, 8'h00, 8'h00);

    // Back-to-back with VALID held.
    run_write(8'h20, 8'h12, 0, 1, 8'h21, 8'h12);
    run_write(8'h21, 8'h12, 1, 0, 8'h00, 8'h00);

    // Repeated address, then reset, then the same address again.
    run_write(8'h30, 8'h0C, 0, 0, 8'h00, 8'h00);
    run_write(8'h30, 8'h1C, 0, 0, 8'h00, 8'h00);
    do_reset();
    run_write(8'h30, 8'h5A, 0, 0, 8'h00, 8'h00);

    // Reset pulsed during the address strobe.
    begin
      int k = 0;
      while (!m_rdy && k < 5000) begin @(negedge clk); k++; end
      addr = 8'h44; data = 8'h99; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      k = 0;
      while (m_wr && k < 5000) begin @(negedge clk); k++; end
      check("abort_saw_strobe", m_wr, 0);
      #2 ic_n = 1'b0;
      #1;
      check("abort_wr_n", m_wr, 1);
      check("abort_cs_n", m_cs, 1);
      check("abort_busy", m_busy, 0);
      @(negedge clk);
      ic_n = 1'b1;
      cvld[0] = 1'b0; cvld[1] = 1'b0;
      lows = 0;
      repeat (1200) begin @(negedge clk); if (!m_wr || !m_cs) lows++; end
      check("abort_no_strobe", lows, 0);
    end

    // Random writes over a small address set, random tick density.
    tmode = 1;
    for (int i = 0; i < 8; i++) begin
      ra = 8'h40 + 8'($urandom_range(0, 2));
      run_write(ra, 8'($urandom), 0, 0, 8'h00, 8'h00);
    end

    // Minimum-timing instance.
    sel = 1;
    for (int i = 0; i < 6; i++) begin
      ra = 8'h50 + 8'($urandom_range(0, 1));
      run_write(ra, 8'($urandom), 0, 0, 8'h00, 8'h00);
    end
    tmode = 0;
    run_write(8'h60, 8'h01, 0, 1, 8'h61, 8'h02);
    run_write(8'h61, 8'h02, 1, 0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
